frame_decoder_fifo: RTL and testbench

//  Parametrised successor to the single-shot frame decoder.
//  - Checks each incoming serial frame for parity and start/stop errors.
//  - Decodes good frames into addr/wdata/we/cmd and queues them in a FIFO_DEPTH-entry FIFO.
//  - Presents queued frames downstream on a valid/ready handshake.
//  - Sits between the serial deserializer (cannot stall) and the bus master/slave interface.

---
 rtl/frame_decoder_fifo.sv | 139 +++++++++++++
 tb/tb_frame_decoder_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_decoder_fifo.sv
// Frame checker/decoder feeding a FIFO_DEPTH-entry queue with a valid/ready head port.
// Define FRAME_DEC_ERR_CNT_EN to build the saturating error/overflow counters.
module frame_decoder_fifo #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 frame_valid_i,
    input  logic                 frame_start_i,
    input  logic                 frame_stop_i,
    input  logic [1:0]           frame_cmd_i,
    input  logic [ADDR_W-1:0]    frame_addr_i,
    input  logic [DATA_W-1:0]    frame_data_i,
    input  logic                 parity_err_i,
    input  logic                 clear_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [ADDR_W-1:0]    addr_o,
    output logic [DATA_W-1:0]    wdata_o,
    output logic [1:0]           cmd_o,
    output logic                 we_o,
    output logic                 err_o,
    output logic [1:0]           err_code_o,
    output logic                 ovf_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [ERR_CNT_W-1:0] ovf_cnt_o
);
    // Command encoding follows bus_pkg.
    localparam logic [1:0] CMD_WRITE       = 2'b01;
    localparam logic [1:0] CMD_SPLIT_START = 2'b10;

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W + 3;

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             ovf_q, ovf_d;

    logic             empty, full;
    logic             framing_bad, frame_bad, frame_good;
    logic             pop, push, drop;
    logic             we_in;
    logic [ENT_W-1:0] entry_in, head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

    assign framing_bad = ~frame_start_i | ~frame_stop_i;
    assign frame_bad   = frame_valid_i & (parity_err_i | framing_bad);
    assign frame_good  = frame_valid_i & ~(parity_err_i | framing_bad);

    // Head handshake: a frame leaves the queue on every rising edge where
    // valid_o & ready_i; while valid_o & !ready_i the head is held unchanged,
    // and ready_i has no effect when valid_o is low.
    assign pop  = ~empty & ready_i;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign push = frame_good & ~clear_i & (~full | pop);
    assign drop = frame_good & ~clear_i & full & ~pop;

    assign we_in    = (frame_cmd_i == CMD_WRITE) || (frame_cmd_i == CMD_SPLIT_START);
    assign entry_in = {frame_addr_i, frame_data_i, frame_cmd_i, we_in};

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        err_d      = frame_bad;
        err_code_d = err_code_q;
        ovf_d      = drop;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (frame_bad) err_code_d = {framing_bad, parity_err_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[IDX_W-1:0]] <= entry_in;
    end

    assign head    = empty ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];
    assign valid_o = ~empty;
    assign addr_o  = head[ENT_W-1 -: ADDR_W];
    assign wdata_o = head[DATA_W+2 -: DATA_W];
    assign cmd_o   = head[2:1];
    assign we_o    = head[0];

    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign ovf_o      = ovf_q;

`ifdef FRAME_DEC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, ovf_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            if (frame_bad && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
            if (drop && !(&ovf_cnt_q))      ovf_cnt_q <= ovf_cnt_q + 1'b1;
        end
    end

    assign err_cnt_o = err_cnt_q;
    assign ovf_cnt_o = ovf_cnt_q;
`else
    assign err_cnt_o = '0;
    assign ovf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_frame_decoder_fifo.sv
// Bench for frame_decoder_fifo: directed steps then random traffic, checked
// every cycle against a queue-based reference model.
module tb_frame_decoder_fifo;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int ERR_CNT_W  = 3;
  localparam int CNT_MAX    = (1 << ERR_CNT_W) - 1;
  localparam int ENT_W      = ADDR_W + DATA_W + 3;

  localparam logic [1:0] CMD_READ        = 2'b00;
  localparam logic [1:0] CMD_WRITE       = 2'b01;
  localparam logic [1:0] CMD_SPLIT_START = 2'b10;
  localparam logic [1:0] CMD_SPLIT_END   = 2'b11;

`ifdef FRAME_DEC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 frame_valid_i, frame_start_i, frame_stop_i;
  logic [1:0]           frame_cmd_i;
  logic [ADDR_W-1:0]    frame_addr_i;
  logic [DATA_W-1:0]    frame_data_i;
  logic                 parity_err_i, clear_i, ready_i;
  logic                 valid_o, we_o, err_o, ovf_o;
  logic [ADDR_W-1:0]    addr_o;
  logic [DATA_W-1:0]    wdata_o;
  logic [1:0]           cmd_o, err_code_o;
  logic [ERR_CNT_W-1:0] err_cnt_o, ovf_cnt_o;

  frame_decoder_fifo #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .frame_valid_i(frame_valid_i), .frame_start_i(frame_start_i), .frame_stop_i(frame_stop_i),
    .frame_cmd_i(frame_cmd_i), .frame_addr_i(frame_addr_i), .frame_data_i(frame_data_i),
    .parity_err_i(parity_err_i), .clear_i(clear_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .addr_o(addr_o), .wdata_o(wdata_o), .cmd_o(cmd_o), .we_o(we_o),
    .err_o(err_o), .err_code_o(err_code_o), .ovf_o(ovf_o),
    .err_cnt_o(err_cnt_o), .ovf_cnt_o(ovf_cnt_o)
  );

  // clock/reset
  always #5 clk_i = ~clk_i;

  // scoreboard state
  logic [ENT_W-1:0] exp_q[$];
  logic             m_err, m_ovf;
  logic [1:0]       m_code;
  int               m_err_cnt, m_ovf_cnt;
  int               checks, errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: compare outputs at the falling edge, advance the model with the
  // inputs the DUT will sample at the next rising edge, then step past it.
  task automatic tick();
    int sz;
    logic bad, good, do_pop, we;
    logic [ENT_W-1:0] head;
    @(negedge clk_i);
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check("valid_o", 32'(valid_o), 32'(exp_q.size() > 0));
    check("addr_o", 32'(addr_o), 32'(head[ENT_W-1 -: ADDR_W]));
    check("wdata_o", 32'(wdata_o), 32'(head[DATA_W+2 -: DATA_W]));
    check("cmd_o", 32'(cmd_o), 32'(head[2:1]));
    check("we_o", 32'(we_o), 32'(head[0]));
    check("err_o", 32'(err_o), 32'(m_err));
    check("err_code_o", 32'(err_code_o), 32'(m_code));
    check("ovf_o", 32'(ovf_o), 32'(m_ovf));
    check("err_cnt_o", 32'(err_cnt_o), CNT_EN ? 32'(m_err_cnt) : 32'd0);
    check("ovf_cnt_o", 32'(ovf_cnt_o), CNT_EN ? 32'(m_ovf_cnt) : 32'd0);

    sz = exp_q.size();
    if (rst_i) begin
      exp_q.delete();
      m_err = 1'b0; m_ovf = 1'b0; m_code = 2'b00;
      m_err_cnt = 0; m_ovf_cnt = 0;
    end else begin
      bad  = frame_valid_i && (parity_err_i || !frame_start_i || !frame_stop_i);
      good = frame_valid_i && !bad;
      m_err = bad;
      m_ovf = 1'b0;
      if (bad) begin
        m_code = {!frame_start_i || !frame_stop_i, parity_err_i};
        if (m_err_cnt < CNT_MAX) m_err_cnt++;
      end
      if (clear_i) begin
        exp_q.delete();
      end else begin
        do_pop = (sz > 0) && ready_i;
        if (do_pop) void'(exp_q.pop_front());
        if (good) begin
          if (sz < FIFO_DEPTH || do_pop) begin
            we = (frame_cmd_i == CMD_WRITE) || (frame_cmd_i == CMD_SPLIT_START);
            exp_q.push_back({frame_addr_i, frame_data_i, frame_cmd_i, we});
          end else begin
            m_ovf = 1'b1;
            if (m_ovf_cnt < CNT_MAX) m_ovf_cnt++;
          end
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  // driver tasks
  task automatic frame(input logic st, input logic sp, input logic par,
                       input logic [1:0] cmd, input logic [15:0] a, input logic [7:0] d);
    frame_valid_i = 1'b1; frame_start_i = st; frame_stop_i = sp; parity_err_i = par;
    frame_cmd_i = cmd; frame_addr_i = a; frame_data_i = d;
  endtask

  task automatic idle();
    frame_valid_i = 1'b0; frame_start_i = 1'b1; frame_stop_i = 1'b1; parity_err_i = 1'b0;
    frame_cmd_i = CMD_READ; frame_addr_i = '0; frame_data_i = '0;
  endtask

  initial begin
    checks = 0; errors = 0;
    m_err = 1'b0; m_ovf = 1'b0; m_code = 2'b00; m_err_cnt = 0; m_ovf_cnt = 0;
    rst_i = 1'b1; clear_i = 1'b0; ready_i = 1'b0;
    idle();
    repeat (3) tick();
    rst_i = 1'b0;
    tick();

    // good write frame, popped on arrival at the head
    ready_i = 1'b1;
    frame(1, 1, 0, CMD_WRITE, 16'h1234, 8'h5A); tick();
    idle(); tick(); tick();

    // parity error then stop-bit error
    frame(1, 1, 1, CMD_WRITE, 16'h0001, 8'h01); tick();
    frame(1, 0, 0, CMD_WRITE, 16'h0002, 8'h02); tick();
    idle(); tick(); tick();

    // five frames into a stalled queue, then drain
    ready_i = 1'b0;
    frame(1, 1, 0, CMD_WRITE,       16'h1000, 8'h11); tick();
    frame(1, 1, 0, CMD_READ,        16'h2000, 8'h22); tick();
    frame(1, 1, 0, CMD_SPLIT_START, 16'h3000, 8'h33); tick();
    frame(1, 1, 0, CMD_SPLIT_END,   16'h4000, 8'h44); tick();
    frame(1, 1, 0, CMD_WRITE,       16'h5000, 8'h55); tick();
    idle(); tick(); tick();
    ready_i = 1'b1;
    repeat (5) tick();

    // full queue: push and pop together
    ready_i = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      frame(1, 1, 0, CMD_WRITE, 16'hA000 + 16'(i), 8'(8'hB0 + i)); tick();
    end
    ready_i = 1'b1;
    frame(1, 1, 0, CMD_SPLIT_START, 16'hA0FF, 8'hBF); tick();
    ready_i = 1'b0; idle(); tick(); tick();
    ready_i = 1'b1;
    repeat (5) tick();

    // clear with three queued; a frame in the clear cycle is still checked
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frame(1, 1, 0, CMD_READ, 16'hC000 + 16'(i), 8'(i)); tick();
    end
    clear_i = 1'b1; frame(0, 1, 0, CMD_WRITE, 16'hDEAD, 8'hEE); tick();
    clear_i = 1'b0; idle(); tick(); tick();

    // error counter saturation
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      frame(1, 1, 1, CMD_READ, 16'(i), 8'(i)); tick();
    end
    idle(); tick();

    // reset mid-operation with frames queued
    for (int i = 0; i < 2; i++) begin
      frame(1, 1, 0, CMD_WRITE, 16'hE000 + 16'(i), 8'(i)); tick();
    end
    frame(1, 1, 1, CMD_WRITE, 16'hE0FF, 8'hFF); tick();
    idle(); rst_i = 1'b1; tick();
    rst_i = 1'b0; tick(); tick();

    // random traffic with stalled phases to exercise overflow and its saturation
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0)
        frame($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
              2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)));
      else
        idle();
      ready_i = ((i % 80) < 40) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      clear_i = ($urandom_range(0, 40) == 0);
      tick();
    end
    idle(); clear_i = 1'b0; ready_i = 1'b1;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
